// File: rtl/vector_sequencer_if.sv
// Handshake and data bundle between a sweep controller and the sequencer.
// The sequencer takes the slave side; the controller or bench is the master.
`timescale 1ns/1ps
interface vector_sequencer_if #(
  parameter int WIDTH = 4
);
  localparam int N = 1 << WIDTH;

  logic             start;
  logic             abort;
  logic [N-1:0]     exp_map;
  logic             resp_in;
  logic [WIDTH-1:0] vec_out;
  logic             vec_valid;
  logic             busy;
  logic             done;
  logic [N-1:0]     resp_map;
  logic             mismatch;
  logic [WIDTH:0]   err_cnt;

  modport master (
    output start,
    output abort,
    output exp_map,
    output resp_in,
    input  vec_out,
    input  vec_valid,
    input  busy,
    input  done,
    input  resp_map,
    input  mismatch,
    input  err_cnt
  );

  modport slave (
    input  start,
    input  abort,
    input  exp_map,
    input  resp_in,
    output vec_out,
    output vec_valid,
    output busy,
    output done,
    output resp_map,
    output mismatch,
    output err_cnt
  );
endinterface

// File: rtl/vector_sequencer.sv
// Exhaustive stimulus sweep: holds each code for DWELL cycles, captures the
// single-bit response on the last dwell cycle, then scores it against exp_map.
`timescale 1ns/1ps
module vector_sequencer #(
  parameter int WIDTH = 4,
  parameter int DWELL = 5
) (
  input logic               clk,
  input logic               rst_n,
  vector_sequencer_if.slave bus
);
  localparam int N = 1 << WIDTH;
  localparam logic [7:0] LAST_DW = 8'(DWELL - 1);
  localparam logic [WIDTH-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [7:0]       dw_cnt;
  logic [WIDTH-1:0] vec_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [N-1:0]     resp_q;
  logic             mism_q;
  logic [WIDTH:0]   err_q;

  logic             dw_last;
  logic [N-1:0]     cap_map;
  logic [N-1:0]     diff;
  logic [WIDTH:0]   diff_cnt;

  assign dw_last = (dw_cnt == LAST_DW);

  // Response map as it will look once the current capture lands; scoring
  // uses this so the final vector is included in the DONE-entry result.
  always_comb begin
    cap_map = resp_q;
    cap_map[vec_q] = bus.resp_in;
  end

  // Bit-difference against the expectation and its population count.
  always_comb begin
    diff = cap_map ^ bus.exp_map;
    diff_cnt = '0;
    for (int i = 0; i < N; i++) begin
      diff_cnt = diff_cnt + {{WIDTH{1'b0}}, diff[i]};
    end
  end

  // Sweep FSM with registered outputs; abort wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dw_cnt  <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= '0;
      mism_q  <= 1'b0;
      err_q   <= '0;
    end else if (bus.abort) begin
      state   <= IDLE;
      dw_cnt  <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            dw_cnt  <= '0;
            vec_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            resp_q  <= '0;
            mism_q  <= 1'b0;
            err_q   <= '0;
          end
        end
        RUN: begin
          if (dw_last) begin
            resp_q <= cap_map;
            dw_cnt <= '0;
            if (vec_q == LAST_VEC) begin
              state   <= DONE;
              vec_q   <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              mism_q  <= |diff;
              err_q   <= diff_cnt;
            end else begin
              vec_q <= vec_q + 1'b1;
            end
          end else begin
            dw_cnt <= dw_cnt + 8'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.vec_out   = vec_q;
  assign bus.vec_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.resp_map  = resp_q;
  assign bus.mismatch  = mism_q;
  assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: table of full sweeps plus
// hand-written abort, contention, reset and DWELL=1 sequences.
`timescale 1ns/1ps
module tb_vector_sequencer;
  localparam int W = 4;
  localparam int D = 5;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vector_sequencer_if #(.WIDTH(W)) bus ();
  vector_sequencer_if #(.WIDTH(W)) bus1 ();

  vector_sequencer #(.WIDTH(W), .DWELL(D)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  vector_sequencer #(.WIDTH(W), .DWELL(1)) u_dw1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  logic [N-1:0] mdl_map;
  logic [N-1:0] flip;

  assign bus.resp_in  = mdl_map[bus.vec_out] ^ flip[bus.vec_out];
  assign bus1.resp_in = 1'b1;

  typedef struct {
    logic [N-1:0] exp_map;
    logic [N-1:0] flip;
    int           poke_at;
    logic [N-1:0] want_map;
    logic         want_mm;
    logic [W:0]   want_err;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input int poke_at, output int n_busy,
                           output int done_at, output int vec_err);
    n_busy = 0;
    done_at = -1;
    vec_err = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int t = 1; t <= 200 && done_at < 0; t++) begin
      bus.start = (t == poke_at);
      if (bus.busy) begin
        n_busy++;
        if (!bus.vec_valid || bus.vec_out != 4'((t - 1) / D)) vec_err++;
      end else if (bus.vec_valid || bus.vec_out != 4'd0) begin
        vec_err++;
      end
      if (bus.done) begin
        done_at = t;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_vec(input logic [W-1:0] v, output bit found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.vec_out == v && bus.busy) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int nb;
    int da;
    int ve;
    int pulses;
    bit found;

    tbl[0] = '{16'h8888, 16'h0000, 0,  16'h8888, 1'b0, 5'd0};
    tbl[1] = '{16'h8888, 16'h1008, 30, 16'h9880, 1'b1, 5'd2};
    tbl[2] = '{16'h0000, 16'hFFFF, 0,  16'hFFFF, 1'b1, 5'd16};
    tbl[3] = '{16'hA5C3, 16'h0000, 0,  16'hA5C3, 1'b0, 5'd0};
    tbl[4] = '{16'h0F0F, 16'h0001, 0,  16'h0F0E, 1'b1, 5'd1};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.exp_map = '0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus1.exp_map = '0;
    mdl_map = '0;
    flip = '0;

    #1;
    chk("rst_vec_out", 32'(bus.vec_out), 0);
    chk("rst_vec_valid", 32'(bus.vec_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_resp_map", 32'(bus.resp_map), 0);
    chk("rst_mismatch", 32'(bus.mismatch), 0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 0);

    #20;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("contend_busy", 32'(bus.busy), 0);
    chk("contend_valid", 32'(bus.vec_valid), 0);

    for (int i = 0; i < 5; i++) begin
      bus.exp_map = tbl[i].exp_map;
      mdl_map = tbl[i].exp_map;
      flip = tbl[i].flip;
      run_sweep(tbl[i].poke_at, nb, da, ve);
      chk($sformatf("t%0d_busy_len", i), 32'(nb), 80);
      chk($sformatf("t%0d_done_at", i), 32'(da), 81);
      chk($sformatf("t%0d_vec_seq", i), 32'(ve), 0);
      chk($sformatf("t%0d_resp_map", i), 32'(bus.resp_map),
          32'(tbl[i].want_map));
      chk($sformatf("t%0d_mismatch", i), 32'(bus.mismatch),
          32'(tbl[i].want_mm));
      chk($sformatf("t%0d_err_cnt", i), 32'(bus.err_cnt),
          32'(tbl[i].want_err));
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_done_pulse", i), 32'(bus.done), 0);
      chk($sformatf("t%0d_idle_busy", i), 32'(bus.busy), 0);
    end

    bus.exp_map = 16'h0F0E;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_mismatch", 32'(bus.mismatch), 1);
    chk("hold_err_cnt", 32'(bus.err_cnt), 1);
    chk("hold_resp_map", 32'(bus.resp_map), 32'h0F0E);

    bus.exp_map = 16'h8888;
    mdl_map = 16'h8888;
    flip = '0;
    start_pulse();
    wait_vec(4'd6, found);
    chk("abort_reach6", 32'(found), 1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_valid", 32'(bus.vec_valid), 0);
    chk("abort_vec_out", 32'(bus.vec_out), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_resp_map", 32'(bus.resp_map), 32'h0008);
    chk("abort_mismatch", 32'(bus.mismatch), 0);
    chk("abort_err_cnt", 32'(bus.err_cnt), 0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 0);

    start_pulse();
    wait_vec(4'd9, found);
    chk("rstmid_reach9", 32'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_vec_out", 32'(bus.vec_out), 0);
    chk("rstmid_valid", 32'(bus.vec_valid), 0);
    chk("rstmid_busy", 32'(bus.busy), 0);
    chk("rstmid_done", 32'(bus.done), 0);
    chk("rstmid_resp_map", 32'(bus.resp_map), 0);
    chk("rstmid_mismatch", 32'(bus.mismatch), 0);
    chk("rstmid_err_cnt", 32'(bus.err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid_waits", 32'(bus.busy), 0);
    run_sweep(0, nb, da, ve);
    chk("rerun_busy_len", 32'(nb), 80);
    chk("rerun_done_at", 32'(da), 81);
    chk("rerun_vec_seq", 32'(ve), 0);
    chk("rerun_resp_map", 32'(bus.resp_map), 32'h8888);
    chk("rerun_mismatch", 32'(bus.mismatch), 0);

    @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("held_start_busy", 32'(bus.busy), 1);
    chk("held_start_vec", 32'(bus.vec_out), 0);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("held_start_abort", 32'(bus.busy), 0);

    bus1.exp_map = 16'hFFFF;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    nb = 0;
    da = -1;
    ve = 0;
    for (int t = 1; t <= 50 && da < 0; t++) begin
      if (bus1.busy) begin
        nb++;
        if (bus1.vec_out != 4'(t - 1)) ve++;
      end
      if (bus1.done) da = t;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("dw1_busy_len", 32'(nb), 16);
    chk("dw1_done_at", 32'(da), 17);
    chk("dw1_vec_seq", 32'(ve), 0);
    chk("dw1_resp_map", 32'(bus1.resp_map), 32'hFFFF);
    chk("dw1_mismatch", 32'(bus1.mismatch), 0);
    chk("dw1_err_cnt", 32'(bus1.err_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
